// File: rtl/cordic_pkg.sv
// cordic_pkg: shared FSM state type and quadrant-fold bit offsets for the CORDIC NCO front end.
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int FOLD_SIGN_OFS = 1;
  localparam int FOLD_QUAD_OFS = 2;
endpackage

// File: rtl/cordic_quadrant_fold.sv
// cordic_quadrant_fold: folds a [-pi,pi) angle into [-pi/2,pi/2) for CORDIC rotation.
//   raw : AW-bit signed angle in
//   ao  : folded angle out, always within [-0.5,0.5)
//   neg : high when the start vector must be negated (-AMP on x)
module cordic_quadrant_fold import cordic_pkg::*; #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] raw,
  output logic [AW-1:0] ao,
  output logic          neg
);
  always_comb begin
    neg = raw[AW-FOLD_SIGN_OFS] ^ raw[AW-FOLD_QUAD_OFS];
    ao = neg ? {~raw[AW-1], raw[AW-2:0]} : raw;
  end
endmodule

// File: rtl/cordic_nco_front.sv
// cordic_nco_front: phase-accumulator NCO producing folded CORDIC (x,y,angle) inputs in bursts.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_we/fcw/poff : load frequency control word and phase offset
//   start/count     : begin a burst of count samples (0 = continuous); stop aborts
//   busy/done       : high in RUN / one-cycle pulse at burst end
//   xo/yo/ao/ovalid : registered sample output, held while ovalid && !oready
module cordic_nco_front import cordic_pkg::*; #(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int PW  = 32,
  parameter int CW  = 16,
  parameter int AMP = 30000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] fcw,
  input  logic [AW-1:0] poff,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] xo,
  output logic [DW-1:0] yo,
  output logic [AW-1:0] ao,
  output logic          ovalid,
  input  logic          oready
);
  localparam logic [DW-1:0] AMP_V = DW'(AMP);
  state_e state_q, state_d;
  logic [PW-1:0] acc_q, acc_d, fcw_q, fcw_d, acc_src;
  logic [AW-1:0] poff_q, poff_d, ao_q, ao_d, raw, fold_ao;
  logic [CW-1:0] rem_q, rem_d, base;
  logic [DW-1:0] xo_q, xo_d;
  logic last_q, last_d, ovalid_q, ovalid_d, busy_q, busy_d, done_q, done_d;
  logic start_ok, run, gen, fold_neg;
  // A start restarts the accumulator at zero, and the first sample is generated on that same edge.
  assign start_ok = state_q == IDLE && start;
  assign acc_src = start_ok ? '0 : acc_q;
  assign raw = acc_src[PW-1 -: AW] + poff_q;
  cordic_quadrant_fold #(.AW(AW)) u_fold (.raw(raw), .ao(fold_ao), .neg(fold_neg));
  always_comb begin
    run = state_q == RUN;
    gen = (!ovalid_q || oready) && (start_ok || (run && !last_q && !stop));
    acc_d = gen ? acc_src + fcw_q : acc_src;
    base = start_ok ? count : rem_q;
    rem_d = (gen && base != '0) ? base - CW'(1) : base;
    // last marks that the pending output is the final sample of a counted burst
    last_d = (start_ok || run) && ((run && last_q) || (gen && base == CW'(1)));
    fcw_d = cfg_we ? fcw : fcw_q;
    poff_d = cfg_we ? poff : poff_q;
    state_d = start_ok ? RUN
            : (run && (stop || (last_q && ovalid_q && oready))) ? DONE
            : state_q == DONE ? IDLE : state_q;
    ovalid_d = gen || (ovalid_q && !oready);
    ao_d = gen ? fold_ao : ao_q;
    xo_d = gen ? (fold_neg ? -AMP_V : AMP_V) : xo_q;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      fcw_q <= '0;
      poff_q <= '0;
      rem_q <= '0;
      last_q <= 1'b0;
      ovalid_q <= 1'b0;
      ao_q <= '0;
      xo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      fcw_q <= fcw_d;
      poff_q <= poff_d;
      rem_q <= rem_d;
      last_q <= last_d;
      ovalid_q <= ovalid_d;
      ao_q <= ao_d;
      xo_q <= xo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign xo = xo_q;
  assign yo = '0;
  assign ao = ao_q;
  assign ovalid = ovalid_q;
endmodule

// File: tb/tb_cordic_nco_front.sv
// tb_cordic_nco_front: scoreboard bench for cordic_nco_front with directed bursts.
module tb_cordic_nco_front;
  logic clk = 0, rst = 1, cfg_we = 0, start = 0, stop = 0, oready = 1;
  logic busy, done, ovalid;
  logic [31:0] fcw = 0;
  logic [15:0] poff = 0, count = 0, xo, yo, ao;
  typedef struct packed {logic [15:0] ao; logic [15:0] xo;} exp_t;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0, hs_cnt = 0, done_cnt = 0, d0 = 0, h0 = 0;
  logic stall_prev = 0;
  logic [15:0] hold_ao, hold_xo;
  localparam logic [15:0] PA = 16'd30000, NA = 16'h8AD0;
  cordic_nco_front dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .fcw(fcw), .poff(poff), .start(start),
    .count(count), .stop(stop), .busy(busy), .done(done), .xo(xo), .yo(yo), .ao(ao),
    .ovalid(ovalid), .oready(oready)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) begin
        compared++;
        if (!ovalid || ao !== hold_ao || xo !== hold_xo) begin
          mismatched++;
          $display("FAIL hold: got ovalid=%b ao=%h xo=%h expected ovalid=1 ao=%h xo=%h", ovalid, ao, xo, hold_ao, hold_xo);
        end
      end
      if (done) done_cnt++;
      if (ovalid && oready) begin
        hs_cnt++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sample: got ao=%h xo=%h with no sample expected", ao, xo);
        end else begin
          e = sb.pop_front();
          if (ao !== e.ao || xo !== e.xo || yo !== 16'h0) begin
            mismatched++;
            $display("FAIL sample: got ao=%h xo=%h yo=%h expected ao=%h xo=%h yo=0000", ao, xo, yo, e.ao, e.xo);
          end
        end
      end
      stall_prev = ovalid && !oready;
      hold_ao = ao;
      hold_xo = xo;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] x);
    sb.push_back('{ao: a, xo: x});
  endtask
  task automatic cfg(input logic [31:0] f, input logic [15:0] p);
    cfg_we = 1; fcw = f; poff = p;
    tick();
    cfg_we = 0;
  endtask
  task automatic mark();
    d0 = done_cnt;
    h0 = hs_cnt;
  endtask
  task automatic launch(input logic [15:0] n);
    start = 1; count = n;
    tick();
    start = 0; stop = 0;
  endtask
  task automatic finish_burst(input int n);
    int k = 0;
    while (!done && k < 60) begin
      tick();
      k++;
    end
    chk("done_seen", {31'b0, done}, 1);
    tick();
    tick();
    chk("busy_end", {31'b0, busy}, 0);
    chk("done_pulse_once", done_cnt - d0, 1);
    chk("handshakes", hs_cnt - h0, n);
    chk("sb_empty", sb.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    chk("rst_ovalid", {31'b0, ovalid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_ao", ao, 0);
    chk("rst_xo", xo, 0);
    chk("rst_yo", yo, 0);
    rst = 0;
    tick();
    // Quarter-turn step, four samples
    cfg(32'h4000_0000, 16'h0000);
    push(16'h0000, PA); push(16'hC000, NA); push(16'h0000, NA); push(16'hC000, PA);
    mark();
    launch(4);
    chk("first_latency_ovalid", {31'b0, ovalid}, 1);
    chk("first_busy", {31'b0, busy}, 1);
    finish_burst(4);
    // Same burst with a three-cycle stall on the second sample
    push(16'h0000, PA); push(16'hC000, NA); push(16'h0000, NA); push(16'hC000, PA);
    mark();
    launch(4);
    tick();
    oready = 0;
    repeat (3) tick();
    oready = 1;
    finish_burst(4);
    // Continuous run stopped after 20 samples while the last one is stalled
    cfg(32'h0100_0000, 16'h0000);
    for (int n = 0; n < 20; n++) push(16'(n * 256), PA);
    mark();
    launch(0);
    repeat (19) tick();
    stop = 1; oready = 0;
    tick();
    stop = 0;
    chk("stop_done", {31'b0, done}, 1);
    chk("stop_busy", {31'b0, busy}, 0);
    chk("stop_pending_ovalid", {31'b0, ovalid}, 1);
    tick();
    chk("stop_done_one_cycle", {31'b0, done}, 0);
    chk("stop_pending_still", {31'b0, ovalid}, 1);
    oready = 1;
    tick();
    tick();
    chk("stop_ovalid_clear", {31'b0, ovalid}, 0);
    chk("stop_handshakes", hs_cnt - h0, 20);
    chk("stop_done_cnt", done_cnt - d0, 1);
    chk("stop_sb_empty", sb.size(), 0);
    // Phase offset only, start with simultaneous stop (start wins)
    cfg(32'h0, 16'h2000);
    repeat (3) push(16'h2000, PA);
    mark();
    start = 1; stop = 1; count = 3;
    tick();
    start = 0; stop = 0;
    finish_burst(3);
    cfg(32'h0, 16'h6000);
    repeat (3) push(16'hE000, NA);
    mark();
    launch(3);
    finish_burst(3);
    // Reset in the middle of a stalled burst
    cfg(32'h4000_0000, 16'h0000);
    oready = 0;
    mark();
    launch(0);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_ovalid", {31'b0, ovalid}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_ao", ao, 0);
    chk("midrst_xo", xo, 0);
    tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_hs", hs_cnt - h0, 0);
    oready = 1;
    cfg(32'h4000_0000, 16'h0000);
    push(16'h0000, PA); push(16'hC000, NA); push(16'h0000, NA); push(16'hC000, PA);
    mark();
    launch(4);
    finish_burst(4);
    // Frequency word rewritten during a burst
    push(16'h0000, PA); push(16'hC000, NA); push(16'h0000, NA); push(16'h1000, NA);
    mark();
    launch(4);
    cfg_we = 1; fcw = 32'h1000_0000;
    tick();
    cfg_we = 0;
    finish_burst(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cordic_nco_front.md
CORDIC_NCO_FRONT -- requirements
Module: cordic_nco_front

Interface
REQ-001 Parameter DW, default 16, sets the x/y sample width (signed Q1.(DW-1)).
REQ-002 Parameter AW, default 16, sets the angle width (signed Q1.(AW-1); [-1,1) maps to [-pi,pi)).
REQ-003 Parameter PW, default 32, sets the phase accumulator width; PW SHALL be >= AW.
REQ-004 Parameter CW, default 16, sets the burst counter width.
REQ-005 Parameter AMP, default 30000, sets the signed DW-bit vector magnitude presented as x.
REQ-006 Clock clk, input, 1 bit; all state SHALL update on the rising edge.
REQ-007 Reset rst, input, 1 bit, synchronous, active-high.
REQ-008 cfg_we, input, 1 bit: loads fcw and poff this cycle.
REQ-009 fcw, input, PW bits, unsigned: frequency control word (phase step per sample).
REQ-010 poff, input, AW bits: phase offset added after truncation.
REQ-011 start, input, 1 bit: starts a burst.
REQ-012 count, input, CW bits: burst length sampled on start; 0 means continuous.
REQ-013 stop, input, 1 bit: aborts a burst.
REQ-014 busy, output, 1 bit: high in RUN.
REQ-015 done, output, 1 bit: one-cycle pulse at burst end.
REQ-016 xo, yo, output, DW bits each, signed: CORDIC x/y inputs.
REQ-017 ao, output, AW bits, signed: CORDIC angle input, always within [-0.5,0.5).
REQ-018 ovalid, output, 1 bit; oready, input, 1 bit: output handshake.

Function
REQ-019 FSM states: IDLE, RUN, DONE. IDLE->RUN on start; RUN->DONE when the last counted sample is accepted or stop is high; DONE->IDLE unconditionally after 1 cycle. done=1 only in DONE.
REQ-020 start: phase accumulator <= 0, remaining counter <= count; start in RUN or DONE is ignored.
REQ-021 Phase raw = acc[PW-1 -: AW] + poff_reg (mod 2^AW); acc <= acc + fcw_reg (mod 2^PW) on each sample generation.
REQ-022 Samples are generated only in RUN, and only when the output register is empty or accepted this cycle (!ovalid || oready).
REQ-023 Quadrant fold: if raw[AW-1] != raw[AW-2], then ao = raw with MSB inverted and xo = -AMP; otherwise ao = raw and xo = AMP. yo is always 0.
REQ-024 Output register: xo/yo/ao/ovalid are registered; latency from start to first ovalid is 1 cycle; while ovalid && !oready all outputs SHALL hold.
REQ-025 Counted burst: remaining decrements on each generated sample; the burst ends when the sample generated with remaining==1 is accepted. Continuous (count==0) runs until stop.
REQ-026 stop is honoured in any cycle of RUN: no further samples are generated; a pending output is still presented until accepted, and ovalid does not deassert early.
REQ-027 cfg_we is accepted in any state; the new fcw/poff SHALL affect the next generated sample only.
REQ-028 Simultaneous start and stop in IDLE: start wins, and stop is ignored.

Reset
REQ-029 rst SHALL set state=IDLE; acc, remaining, fcw_reg, poff_reg, xo, yo, ao = 0; ovalid, busy, done = 0.
REQ-030 rst mid-burst SHALL discard any pending sample without a done pulse.

Structure
REQ-031 A shared package cordic_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the fold localparams.
REQ-032 The quadrant fold SHALL be the sub-module cordic_quadrant_fold (combinational; raw angle in; ao and sign-of-x out).

Verification
REQ-033 fcw=0x4000_0000, poff=0, start with count=4, oready=1: (ao,xo) sequence = (0x0000,+30000), (0xC000,-30000), (0x0000,-30000), (0xC000,+30000); then done pulses once and busy drops.
REQ-034 Same as REQ-033 with oready low for 3 cycles on the second sample: the outputs hold, no sample is lost or duplicated, and exactly 4 handshakes occur.
REQ-035 count=0, fcw=0x0100_0000, assert stop at cycle 20: samples stop, the final pending sample completes, done=1 for 1 cycle, and the acc value is consistent with the number of samples.
REQ-036 poff=0x2000 with fcw=0: every ao=0x2000 and xo=+30000; with poff=0x6000, every ao=0xE000 and xo=-30000.
REQ-037 Assert rst in the middle of a burst: the next cycle has all outputs at 0, state IDLE, and no done pulse; a new start then works normally.
REQ-038 cfg_we with fcw changed mid-burst: the phase step changes starting from the next generated sample.
